io_bridge: RTL and testbench

Bidirectional word-buffering I/O stage between the processor core's 16-bit `data_in`/`data_out` pins and an external producer/consumer. External words enter an input FIFO that the core drains. Core words enter an output FIFO that drains to the external sink through a valid/ready handshake. Illegal core accesses (pop from empty, push to full) raise a sticky `fault` that is ORed with the core's own fault at the top level.

---
 rtl/io_bridge_if.sv | 33 +++
 rtl/io_bridge.sv | 86 ++++++++
 tb/tb_io_bridge.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/io_bridge_if.sv
// Signal bundle between io_bridge and its core/external neighbours.
// The bridge takes the slave view; whoever drives the inputs takes the master view.
interface io_bridge_if #(
  parameter int DEPTH_LOG = 3
);
  logic [15:0]        ext_in_data;
  logic               ext_in_valid;
  logic               ext_in_ready;
  logic               cpu_rd;
  logic [15:0]        cpu_rd_data;
  logic               cpu_in_empty;
  logic               cpu_wr;
  logic [15:0]        cpu_wr_data;
  logic               cpu_out_full;
  logic [15:0]        ext_out_data;
  logic               ext_out_valid;
  logic               ext_out_ready;
  logic [DEPTH_LOG:0] in_count;
  logic [DEPTH_LOG:0] out_count;
  logic               fault;

  modport master (
    output ext_in_data, ext_in_valid, cpu_rd, cpu_wr, cpu_wr_data, ext_out_ready,
    input  ext_in_ready, cpu_rd_data, cpu_in_empty, cpu_out_full,
           ext_out_data, ext_out_valid, in_count, out_count, fault
  );

  modport slave (
    input  ext_in_data, ext_in_valid, cpu_rd, cpu_wr, cpu_wr_data, ext_out_ready,
    output ext_in_ready, cpu_rd_data, cpu_in_empty, cpu_out_full,
           ext_out_data, ext_out_valid, in_count, out_count, fault
  );
endinterface

// File: rtl/io_bridge.sv
// Two independent circular FIFOs between the core's data pins and an external
// producer/consumer, plus a sticky fault for illegal core accesses.
module io_bridge #(
  parameter int DEPTH_LOG = 3
) (
  input logic        clk,
  input logic        rst,
  io_bridge_if.slave bus
);
  localparam int DEPTH = 1 << DEPTH_LOG;
  localparam logic [DEPTH_LOG:0]   FULL_CNT = (DEPTH_LOG + 1)'(DEPTH);
  localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);
  localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG + 1)'(1);

  // Handshake: a word moves on a rising edge exactly when valid && ready were
  // both high before that edge; ready/valid come from registered state only.

  logic [15:0]          r_in_mem  [DEPTH];
  logic [DEPTH_LOG-1:0] r_in_wptr;
  logic [DEPTH_LOG-1:0] r_in_rptr;
  logic [DEPTH_LOG:0]   r_in_count;

  logic [15:0]          r_out_mem [DEPTH];
  logic [DEPTH_LOG-1:0] r_out_wptr;
  logic [DEPTH_LOG-1:0] r_out_rptr;
  logic [DEPTH_LOG:0]   r_out_count;

  logic                 r_fault;

  logic w_in_full, w_in_empty, w_in_push, w_in_pop;
  logic w_out_full, w_out_empty, w_out_push, w_out_pop;
  logic w_bad_rd, w_bad_wr;

  assign w_in_full   = (r_in_count == FULL_CNT);
  assign w_in_empty  = (r_in_count == '0);
  assign w_out_full  = (r_out_count == FULL_CNT);
  assign w_out_empty = (r_out_count == '0);

  assign w_in_push  = bus.ext_in_valid && !w_in_full;
  assign w_in_pop   = bus.cpu_rd && !w_in_empty;
  assign w_out_push = bus.cpu_wr && !w_out_full;
  assign w_out_pop  = !w_out_empty && bus.ext_out_ready;

  assign w_bad_rd = bus.cpu_rd && w_in_empty;
  assign w_bad_wr = bus.cpu_wr && w_out_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_wptr   <= '0;
      r_in_rptr   <= '0;
      r_in_count  <= '0;
      r_out_wptr  <= '0;
      r_out_rptr  <= '0;
      r_out_count <= '0;
      r_fault     <= 1'b0;
    end else begin
      if (w_in_push) r_in_wptr <= r_in_wptr + PTR_ONE;
      if (w_in_pop)  r_in_rptr <= r_in_rptr + PTR_ONE;
      if (w_in_push && !w_in_pop)      r_in_count <= r_in_count + CNT_ONE;
      else if (!w_in_push && w_in_pop) r_in_count <= r_in_count - CNT_ONE;

      if (w_out_push) r_out_wptr <= r_out_wptr + PTR_ONE;
      if (w_out_pop)  r_out_rptr <= r_out_rptr + PTR_ONE;
      if (w_out_push && !w_out_pop)      r_out_count <= r_out_count + CNT_ONE;
      else if (!w_out_push && w_out_pop) r_out_count <= r_out_count - CNT_ONE;

      if (w_bad_rd || w_bad_wr) r_fault <= 1'b1;
    end
  end

  // Storage is not reset; stale entries are never visible because heads are gated by empty.
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wptr]   <= bus.ext_in_data;
    if (w_out_push) r_out_mem[r_out_wptr] <= bus.cpu_wr_data;
  end

  assign bus.ext_in_ready  = !w_in_full;
  assign bus.cpu_in_empty  = w_in_empty;
  assign bus.cpu_rd_data   = w_in_empty ? 16'h0000 : r_in_mem[r_in_rptr];
  assign bus.cpu_out_full  = w_out_full;
  assign bus.ext_out_valid = !w_out_empty;
  assign bus.ext_out_data  = w_out_empty ? 16'h0000 : r_out_mem[r_out_rptr];
  assign bus.in_count      = r_in_count;
  assign bus.out_count     = r_out_count;
  assign bus.fault         = r_fault;
endmodule

// File: tb/tb_io_bridge.sv
// Bench for io_bridge: queue-based reference model checked every cycle,
// directed scenarios with literal expectations.
module tb_io_bridge;
  localparam int DL    = 3;
  localparam int DEPTH = 1 << DL;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  io_bridge_if #(.DEPTH_LOG(DL)) bus ();
  io_bridge #(.DEPTH_LOG(DL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one queue per FIFO, sticky fault flag.
  logic [15:0] m_in_q[$];
  logic [15:0] m_out_q[$];
  bit          m_fault;
  bit          m_in_push, m_in_pop, m_out_push, m_out_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_in_q.delete();
      m_out_q.delete();
      m_fault = 1'b0;
    end else begin
      m_in_push  = bus.ext_in_valid && (m_in_q.size() < DEPTH);
      m_in_pop   = bus.cpu_rd && (m_in_q.size() > 0);
      m_out_push = bus.cpu_wr && (m_out_q.size() < DEPTH);
      m_out_pop  = bus.ext_out_ready && (m_out_q.size() > 0);
      if (bus.cpu_rd && m_in_q.size() == 0)      m_fault = 1'b1;
      if (bus.cpu_wr && m_out_q.size() == DEPTH) m_fault = 1'b1;
      if (m_in_pop)   void'(m_in_q.pop_front());
      if (m_in_push)  m_in_q.push_back(bus.ext_in_data);
      if (m_out_pop)  void'(m_out_q.pop_front());
      if (m_out_push) m_out_q.push_back(bus.cpu_wr_data);
    end
  end

  // Compare process plus transfer logs taken from the DUT pins.
  bit          chk_en = 1'b0;
  logic [15:0] rd_log[$];
  logic [15:0] out_log[$];
  bit          prev_hold = 1'b0;
  logic [15:0] prev_data;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ext_in_ready",  bus.ext_in_ready,  32'(m_in_q.size() < DEPTH));
      chk("cpu_in_empty",  bus.cpu_in_empty,  32'(m_in_q.size() == 0));
      chk("cpu_rd_data",   bus.cpu_rd_data,   (m_in_q.size() != 0) ? 32'(m_in_q[0]) : 32'h0);
      chk("in_count",      bus.in_count,      32'(m_in_q.size()));
      chk("cpu_out_full",  bus.cpu_out_full,  32'(m_out_q.size() == DEPTH));
      chk("ext_out_valid", bus.ext_out_valid, 32'(m_out_q.size() != 0));
      chk("ext_out_data",  bus.ext_out_data,  (m_out_q.size() != 0) ? 32'(m_out_q[0]) : 32'h0);
      chk("out_count",     bus.out_count,     32'(m_out_q.size()));
      chk("fault",         bus.fault,         32'(m_fault));
      if (!rst && prev_hold) begin
        chk("out_hold_valid", bus.ext_out_valid, 32'h1);
        chk("out_hold_data",  bus.ext_out_data,  32'(prev_data));
      end
      if (!rst && bus.cpu_rd && !bus.cpu_in_empty)        rd_log.push_back(bus.cpu_rd_data);
      if (!rst && bus.ext_out_valid && bus.ext_out_ready) out_log.push_back(bus.ext_out_data);
      prev_hold = !rst && bus.ext_out_valid && !bus.ext_out_ready;
      prev_data = bus.ext_out_data;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic idle();
    bus.ext_in_valid  = 1'b0;
    bus.ext_in_data   = 16'h0;
    bus.cpu_rd        = 1'b0;
    bus.cpu_wr        = 1'b0;
    bus.cpu_wr_data   = 16'h0;
    bus.ext_out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ext_in_valid  = 1'($urandom_range(0, 1));
    bus.ext_in_data   = 16'($urandom_range(0, 16'hFFFF));
    bus.cpu_rd        = 1'($urandom_range(0, 1));
    bus.cpu_wr        = 1'($urandom_range(0, 1));
    bus.cpu_wr_data   = 16'($urandom_range(0, 16'hFFFF));
    bus.ext_out_ready = 1'($urandom_range(0, 1));
    cyc(2);
    rst = 1'b0;
    idle();
    rd_log.delete();
    out_log.delete();
  endtask

  // Producer step: drops valid once the word has been accepted on this edge.
  task automatic prod_step();
    bit go;
    go = bus.ext_in_valid && bus.ext_in_ready;
    cyc();
    if (go) bus.ext_in_valid = 1'b0;
  endtask

  initial begin
    idle();
    #1;
    chk_en = 1'b1;

    // Reset values
    do_reset();
    chk("rst_in_ready",  bus.ext_in_ready,  32'h1);
    chk("rst_in_empty",  bus.cpu_in_empty,  32'h1);
    chk("rst_out_full",  bus.cpu_out_full,  32'h0);
    chk("rst_out_valid", bus.ext_out_valid, 32'h0);
    chk("rst_rd_data",   bus.cpu_rd_data,   32'h0);
    chk("rst_out_data",  bus.ext_out_data,  32'h0);
    chk("rst_counts",    {bus.in_count, bus.out_count}, 32'h0);
    chk("rst_fault",     bus.fault,         32'h0);

    // Input fill: 0001..0008 accepted, 0009 held off
    bus.ext_in_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      bus.ext_in_data = 16'(k);
      cyc();
    end
    bus.ext_in_data = 16'h0009;
    cyc();
    chk("fill_ready", bus.ext_in_ready, 32'h0);
    chk("fill_count", bus.in_count,     32'h8);
    chk("fill_head",  bus.cpu_rd_data,  32'h1);

    // Input drain with read pulses; 0009 enters once space opens
    for (int k = 0; k < 8; k++) begin
      bus.cpu_rd = 1'b1;
      prod_step();
      bus.cpu_rd = 1'b0;
      prod_step();
    end
    chk("drain_log_size", rd_log.size(), 32'h8);
    for (int i = 0; i < 8 && i < rd_log.size(); i++) chk("drain_order", rd_log[i], 32'(i + 1));
    chk("drain_count", bus.in_count,    32'h1);
    chk("drain_head",  bus.cpu_rd_data, 32'h9);
    chk("drain_fault", bus.fault,       32'h0);
    bus.cpu_rd = 1'b1;
    cyc();
    bus.cpu_rd = 1'b0;
    chk("drain_last", (rd_log.size() == 9) ? 32'(rd_log[8]) : 32'hFFFF_FFFF, 32'h9);
    chk("drain_empty", bus.in_count, 32'h0);

    // Output path with backpressure
    bus.ext_out_ready = 1'b0;
    bus.cpu_wr = 1'b1;
    bus.cpu_wr_data = 16'hA5A5;
    cyc();
    bus.cpu_wr_data = 16'h5A5A;
    cyc();
    bus.cpu_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", bus.ext_out_valid, 32'h1);
      chk("bp_data",  bus.ext_out_data,  32'hA5A5);
      cyc();
    end
    bus.ext_out_ready = 1'b1;
    cyc();
    chk("bp_second", bus.ext_out_data, 32'h5A5A);
    cyc();
    chk("bp_done_valid", bus.ext_out_valid, 32'h0);
    chk("bp_log_size", out_log.size(), 32'h2);
    chk("bp_log0", (out_log.size() > 0) ? 32'(out_log[0]) : 32'hFFFF_FFFF, 32'hA5A5);
    chk("bp_log1", (out_log.size() > 1) ? 32'(out_log[1]) : 32'hFFFF_FFFF, 32'h5A5A);
    bus.ext_out_ready = 1'b0;

    // Fault on empty read with a same-cycle external push
    do_reset();
    bus.cpu_rd = 1'b1;
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data = 16'h1234;
    cyc();
    idle();
    chk("er_fault",   bus.fault,       32'h1);
    chk("er_rd_data", bus.cpu_rd_data, 32'h1234);
    chk("er_count",   bus.in_count,    32'h1);
    cyc(3);
    chk("er_sticky",  bus.fault,       32'h1);

    // Fault on full write, with a same-cycle external pop
    do_reset();
    bus.cpu_wr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.cpu_wr_data = 16'h0100 + 16'(i);
      cyc();
    end
    chk("fw_full",  bus.cpu_out_full, 32'h1);
    chk("fw_count", bus.out_count,    32'h8);
    bus.cpu_wr_data = 16'hDEAD;
    bus.ext_out_ready = 1'b1;
    cyc();
    bus.cpu_wr = 1'b0;
    chk("fw_fault",   bus.fault,     32'h1);
    chk("fw_count7",  bus.out_count, 32'h7);
    cyc(7);
    chk("fw_drained", bus.out_count, 32'h0);
    chk("fw_log_size", out_log.size(), 32'h8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk("fw_order", out_log[i], 32'h0100 + 32'(i));
    bus.ext_out_ready = 1'b0;

    // Wrap-around: 20 words each way, push+pop every cycle in steady state
    do_reset();
    bus.ext_in_valid = 1'b1;
    bus.ext_in_data = 16'h2000;
    bus.cpu_wr = 1'b1;
    bus.cpu_wr_data = 16'h3000;
    bus.ext_out_ready = 1'b1;
    cyc();
    for (int i = 1; i < 20; i++) begin
      bus.ext_in_data = 16'h2000 + 16'(i);
      bus.cpu_wr_data = 16'h3000 + 16'(i);
      bus.cpu_rd = 1'b1;
      cyc();
      if (i == 10) begin
        chk("wr_in_steady",  bus.in_count,  32'h1);
        chk("wr_out_steady", bus.out_count, 32'h1);
      end
    end
    bus.ext_in_valid = 1'b0;
    bus.cpu_wr = 1'b0;
    cyc();
    idle();
    cyc();
    chk("wr_rd_size",  rd_log.size(),  32'd20);
    chk("wr_out_size", out_log.size(), 32'd20);
    for (int i = 0; i < 20 && i < rd_log.size(); i++)  chk("wr_rd_order",  rd_log[i],  32'h2000 + 32'(i));
    for (int i = 0; i < 20 && i < out_log.size(); i++) chk("wr_out_order", out_log[i], 32'h3000 + 32'(i));
    chk("wr_fault",  bus.fault, 32'h0);
    chk("wr_counts", {bus.in_count, bus.out_count}, 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
